// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU requester: operation encodings, the command
// payload carried through the command FIFO, and the requester FSM states.
package tinyalu_pkg;

  localparam int unsigned OP_W     = 3;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned RESULT_W = 16;

  typedef enum logic [OP_W-1:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  // op is kept as raw bits so the unused codes (101, 110) can be carried.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    NOP,
    RSTP,
    RESP
  } state_t;

  // True for the ops that produce a result through the start/done handshake.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    case (op)
      add_op, and_op, xor_op, mul_op: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Synchronous FIFO of command structs.
// Ports: clk, reset (async, active-high), push/push_data, pop, head (current
// oldest entry), full, empty. A push while full is accepted only together
// with a pop in the same cycle.
module tinyalu_cmd_fifo
  import tinyalu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  cmd_t         mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra MSB on each pointer distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage; contents are only observed once pointers say they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tinyalu_requester.sv
// Synthesizable initiator for the TinyALU start/done protocol.
// Commands arrive on cmd_valid/cmd_ready (cmd_op, cmd_a, cmd_b), are buffered
// in a CMD_DEPTH-entry FIFO, and are issued one at a time on alu_a/alu_b/
// alu_op/alu_start/alu_reset_n. Results from alu_done/alu_result return on
// rsp_valid/rsp_ready (rsp_result, rsp_op, rsp_err). busy flags pending work.
// Optional macro TINYALU_REQ_TIMEOUT_EN: abort an op after TIMEOUT_CYC cycles
// without alu_done and return a zero result with rsp_err set.
module tinyalu_requester
  import tinyalu_pkg::*;
#(
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_W-1:0]     cmd_op,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [RESULT_W-1:0] rsp_result,
  output logic [OP_W-1:0]     rsp_op,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  output logic                alu_start,
  output logic                alu_reset_n,
  input  logic                alu_done,
  input  logic [RESULT_W-1:0] alu_result,
  output logic                busy
);

  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);

  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 ||
      RST_CYCLES < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("tinyalu_requester: illegal parameter value");
  end

  state_t           state;
  cmd_t             cmd_in;
  cmd_t             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [RST_W-1:0] rst_cnt;

  assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign busy      = (state != IDLE) || !fifo_empty;

  tinyalu_cmd_fifo #(
    .DEPTH(CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid && cmd_ready),
    .push_data (cmd_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef TINYALU_REQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  // Requester FSM with registered ALU and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_start   <= 1'b0;
      alu_reset_n <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_op      <= '0;
`ifdef TINYALU_REQ_TIMEOUT_EN
      rsp_err     <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      // ALU reset is released unless an rst_op is being serviced.
      alu_reset_n <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            alu_a  <= fifo_head.a;
            alu_b  <= fifo_head.b;
            alu_op <= fifo_head.op;
            if (is_alu_op(fifo_head.op)) begin
              alu_start <= 1'b1;
              state     <= ISSUE;
`ifdef TINYALU_REQ_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end else if (fifo_head.op == rst_op) begin
              alu_reset_n <= 1'b0;
              rst_cnt     <= RST_W'(RST_CYCLES - 1);
              state       <= RSTP;
            end else begin
              // no_op and the unused codes: single start pulse, no response.
              alu_start <= 1'b1;
              state     <= NOP;
            end
          end
        end
        ISSUE: begin
          if (alu_done) begin
            rsp_result <= alu_result;
            rsp_op     <= alu_op;
            rsp_valid  <= 1'b1;
            alu_start  <= 1'b0;
            state      <= RESP;
`ifdef TINYALU_REQ_TIMEOUT_EN
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            rsp_result <= '0;
            rsp_op     <= alu_op;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
            alu_start  <= 1'b0;
            state      <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
          end
        end
        NOP: begin
          alu_start <= 1'b0;
          state     <= IDLE;
        end
        RSTP: begin
          if (rst_cnt == '0) begin
            state <= IDLE;
          end else begin
            alu_reset_n <= 1'b0;
            rst_cnt     <= rst_cnt - RST_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef TINYALU_REQ_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_requester.sv
// Directed bench for tinyalu_requester with a small behavioural ALU responder.
module tb_tinyalu_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_reset_n;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;

  bit tie_done_low = 1'b0;

  tinyalu_requester dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_reset_n(alu_reset_n),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add/and/xor answer one cycle after start is seen, mul
  // three cycles after; no_op never answers. Re-arms only after start drops.
  logic m_active;
  logic m_wait;
  int   m_cnt;
  always @(posedge clk) begin
    alu_done <= 1'b0;
    if (reset || !alu_reset_n) begin
      m_active   <= 1'b0;
      m_wait     <= 1'b0;
      m_cnt      <= 0;
      alu_result <= 16'h0000;
    end else if (m_active) begin
      if (m_cnt == 0) begin
        alu_done <= 1'b1;
        m_active <= 1'b0;
        m_wait   <= 1'b1;
        case (alu_op)
          3'b001:  alu_result <= 16'(alu_a) + 16'(alu_b);
          3'b010:  alu_result <= {8'h00, alu_a & alu_b};
          3'b011:  alu_result <= {8'h00, alu_a ^ alu_b};
          default: alu_result <= 16'(alu_a) * 16'(alu_b);
        endcase
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (m_wait) begin
      if (!alu_start) m_wait <= 1'b0;
    end else if (alu_start && !tie_done_low && alu_op >= 3'b001 && alu_op <= 3'b100) begin
      m_active <= 1'b1;
      m_cnt    <= (alu_op == 3'b100) ? 2 : 0;
    end
  end

  // Mid-cycle activity counters used by the scenarios.
  int   start_cycles = 0;
  int   start_rises  = 0;
  int   rstn_low     = 0;
  int   rsp_hs       = 0;
  int   unstable     = 0;
  logic start_prev   = 1'b0;
  logic [18:0] opnd_prev = '0;
  always @(negedge clk) begin
    if (reset) begin
      start_prev <= 1'b0;
    end else begin
      if (alu_start) start_cycles <= start_cycles + 1;
      if (alu_start && !start_prev) start_rises <= start_rises + 1;
      if (alu_start && start_prev && ({alu_op, alu_a, alu_b} != opnd_prev)) unstable <= unstable + 1;
      if (!alu_reset_n) rstn_low <= rstn_low + 1;
      if (rsp_valid && rsp_ready) rsp_hs <= rsp_hs + 1;
      start_prev <= alu_start;
      opnd_prev  <= {alu_op, alu_a, alu_b};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command and return one cycle after it is accepted.
  task automatic push_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) step();
    step();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, capture it, then accept it.
  task automatic get_rsp(output logic [15:0] res, output logic [2:0] op,
                         output logic err, output bit ok);
    ok  = 1'b0;
    res = 16'h0000;
    op  = 3'b000;
    err = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      res       = rsp_result;
      op        = rsp_op;
      err       = rsp_err;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    rsp_ready = 1'b0;
    repeat (3) step();
    vectors++;
    if ({rsp_valid, rsp_result, rsp_op, rsp_err, alu_a, alu_b, alu_op, alu_start, alu_reset_n, busy} !== 47'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", {rsp_valid, rsp_result, rsp_op, rsp_err, alu_a, alu_b, alu_op, alu_start, alu_reset_n, busy});
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
    reset = 1'b0;
    step();
    vectors++;
    if (alu_reset_n !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_alu_reset_n_rise: got %b expected 1", alu_reset_n);
    end
  endtask

  task automatic test_add();
    logic [15:0] res; logic [2:0] op; logic err; bit ok; int s0;
    s0 = start_cycles;
    push_cmd(3'b001, 8'h12, 8'h34);
    vectors++;
    if (alu_start !== 1'b0) begin
      miscompares++;
      $display("FAIL add_start_early: got %b expected 0", alu_start);
    end
    step();
    vectors++;
    if ({alu_start, alu_op, alu_a, alu_b} !== {1'b1, 3'b001, 8'h12, 8'h34}) begin
      miscompares++;
      $display("FAIL add_issue: got %h expected %h", {alu_start, alu_op, alu_a, alu_b}, {1'b1, 3'b001, 8'h12, 8'h34});
    end
    get_rsp(res, op, err, ok);
    vectors++;
    if ({ok, res, op, err} !== {1'b1, 16'h0046, 3'b001, 1'b0}) begin
      miscompares++;
      $display("FAIL add_rsp: got ok=%b res=%h op=%b err=%b expected ok=1 res=0046 op=001 err=0", ok, res, op, err);
    end
    vectors++;
    if (start_cycles - s0 !== 3) begin
      miscompares++;
      $display("FAIL add_start_len: got %0d expected 3", start_cycles - s0);
    end
  endtask

  task automatic test_mul();
    logic [15:0] res; logic [2:0] op; logic err; bit ok; int s0;
    s0 = start_cycles;
    push_cmd(3'b100, 8'hFF, 8'hFF);
    get_rsp(res, op, err, ok);
    vectors++;
    if ({ok, res, op} !== {1'b1, 16'hFE01, 3'b100}) begin
      miscompares++;
      $display("FAIL mul_rsp: got ok=%b res=%h op=%b expected ok=1 res=fe01 op=100", ok, res, op);
    end
    vectors++;
    if (start_cycles - s0 !== 5) begin
      miscompares++;
      $display("FAIL mul_start_len: got %0d expected 5", start_cycles - s0);
    end
    vectors++;
    if (unstable !== 0) begin
      miscompares++;
      $display("FAIL operand_stability: got %0d changes expected 0", unstable);
    end
  endtask

  task automatic test_nop_xor();
    logic [15:0] res; logic [2:0] op; logic err; bit ok; int s0, r0, h0;
    s0 = start_cycles; r0 = start_rises; h0 = rsp_hs;
    push_cmd(3'b000, 8'h00, 8'h00);
    push_cmd(3'b011, 8'hF0, 8'h3C);
    get_rsp(res, op, err, ok);
    vectors++;
    if ({ok, res, op} !== {1'b1, 16'h00CC, 3'b011}) begin
      miscompares++;
      $display("FAIL xor_rsp: got ok=%b res=%h op=%b expected ok=1 res=00cc op=011", ok, res, op);
    end
    vectors++;
    if ({start_cycles - s0, start_rises - r0, rsp_hs - h0} !== {32'd4, 32'd2, 32'd1}) begin
      miscompares++;
      $display("FAIL nop_pulse: got start_cycles=%0d rises=%0d rsps=%0d expected 4 2 1", start_cycles - s0, start_rises - r0, rsp_hs - h0);
    end
  endtask

  task automatic test_rst_op();
    logic [15:0] res; logic [2:0] op; logic err; bit ok; int l0, h0;
    l0 = rstn_low; h0 = rsp_hs;
    push_cmd(3'b111, 8'h00, 8'h00);
    push_cmd(3'b010, 8'h0F, 8'hFF);
    get_rsp(res, op, err, ok);
    vectors++;
    if ({ok, res, op} !== {1'b1, 16'h000F, 3'b010}) begin
      miscompares++;
      $display("FAIL and_after_rst: got ok=%b res=%h op=%b expected ok=1 res=000f op=010", ok, res, op);
    end
    vectors++;
    if ({rstn_low - l0, rsp_hs - h0} !== {32'd2, 32'd1}) begin
      miscompares++;
      $display("FAIL rst_op_pulse: got low_cycles=%0d rsps=%0d expected 2 1", rstn_low - l0, rsp_hs - h0);
    end
  endtask

  logic [7:0]  bp_a   [6] = '{8'h01, 8'h7F, 8'hFF, 8'h80, 8'hAA, 8'hFF};
  logic [7:0]  bp_b   [6] = '{8'h02, 8'h01, 8'h01, 8'h80, 8'h55, 8'hFF};
  logic [15:0] bp_exp [6] = '{16'h0003, 16'h0080, 16'h0100, 16'h0100, 16'h00FF, 16'h01FE};

  task automatic test_back_to_back();
    logic [15:0] res; logic [2:0] op; logic err; bit ok; int acc; logic rdy;
    acc = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      cmd_valid = 1'b1;
      cmd_op    = 3'b001;
      cmd_a     = bp_a[acc];
      cmd_b     = bp_b[acc];
      rdy = cmd_ready;
      step();
      if (rdy) acc++;
    end
    cmd_valid = 1'b0;
    vectors++;
    if ({acc, cmd_ready, busy} !== {32'd5, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL backpressure_accepts: got accepts=%0d ready=%b busy=%b expected 5 0 1", acc, cmd_ready, busy);
    end
    vectors++;
    if ({rsp_valid, rsp_result} !== {1'b1, 16'h0003}) begin
      miscompares++;
      $display("FAIL backpressure_hold: got valid=%b res=%h expected 1 0003", rsp_valid, rsp_result);
    end
    for (int i = 0; i < 5; i++) begin
      get_rsp(res, op, err, ok);
      vectors++;
      if ({ok, res} !== {1'b1, bp_exp[i]}) begin
        miscompares++;
        $display("FAIL drain_%0d: got ok=%b res=%h expected ok=1 res=%h", i, ok, res, bp_exp[i]);
      end
    end
    push_cmd(3'b001, bp_a[5], bp_b[5]);
    get_rsp(res, op, err, ok);
    vectors++;
    if ({ok, res} !== {1'b1, bp_exp[5]}) begin
      miscompares++;
      $display("FAIL drain_5: got ok=%b res=%h expected ok=1 res=%h", ok, res, bp_exp[5]);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drained_busy: got %b expected 0", busy);
    end
  endtask

`ifdef TINYALU_REQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [15:0] res; logic [2:0] op; logic err; bit ok; int s0;
    tie_done_low = 1'b1;
    s0 = start_cycles;
    push_cmd(3'b001, 8'h11, 8'h22);
    get_rsp(res, op, err, ok);
    vectors++;
    if ({ok, res, err} !== {1'b1, 16'h0000, 1'b1}) begin
      miscompares++;
      $display("FAIL timeout_rsp: got ok=%b res=%h err=%b expected ok=1 res=0000 err=1", ok, res, err);
    end
    vectors++;
    if (start_cycles - s0 !== 16) begin
      miscompares++;
      $display("FAIL timeout_len: got %0d expected 16", start_cycles - s0);
    end
    vectors++;
    if ({rsp_err, rsp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL timeout_err_clear: got err=%b valid=%b expected 0 0", rsp_err, rsp_valid);
    end
    tie_done_low = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_issue();
    tie_done_low = 1'b1;
    push_cmd(3'b100, 8'h5A, 8'hA5);
    push_cmd(3'b001, 8'h01, 8'h01);
    repeat (2) step();
    vectors++;
    if ({alu_start, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL mid_issue_active: got start=%b busy=%b expected 1 1", alu_start, busy);
    end
    reset = 1'b1;
    #2;
    vectors++;
    if ({rsp_valid, rsp_result, rsp_op, rsp_err, alu_a, alu_b, alu_op, alu_start, alu_reset_n, busy} !== 47'h0) begin
      miscompares++;
      $display("FAIL mid_issue_reset: got %h expected 0", {rsp_valid, rsp_result, rsp_op, rsp_err, alu_a, alu_b, alu_op, alu_start, alu_reset_n, busy});
    end
    step();
    reset = 1'b0;
    tie_done_low = 1'b0;
    repeat (3) step();
    vectors++;
    if ({alu_reset_n, alu_start, busy, cmd_ready} !== 4'b1001) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b expected 1001", {alu_reset_n, alu_start, busy, cmd_ready});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_nop_xor();
    test_rst_op();
    test_back_to_back();
`ifdef TINYALU_REQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
